// File: rtl/uop_types_pkg.sv
// rtl/uop_types_pkg.sv - shared core parameters and mul/div uop types
package cpu_params;
    localparam int XLEN    = 32;
    localparam int ROB_IDX = 5;
    localparam int PRF_IDX = 6;
endpackage

package uop_types;
    localparam int XLEN    = cpu_params::XLEN;
    localparam int ROB_IDX = cpu_params::ROB_IDX;
    localparam int PRF_IDX = cpu_params::PRF_IDX;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } md_div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/fu_div_iter_div_step.sv
// rtl/fu_div_iter_div_step.sv - one restoring radix-2 division iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;

    // Shift in the next dividend bit; the compare keeps the carry bit, and the
    // difference always fits in XLEN bits when the subtract is taken.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/fu_div_iter.sv
// rtl/fu_div_iter.sv - iterative RV32M DIV/DIVU/REM/REMU functional unit
module fu_div_iter
    import uop_types::*;
#(
    parameter int XLEN    = cpu_params::XLEN,
    parameter int ROB_IDX = cpu_params::ROB_IDX,
    parameter int PRF_IDX = cpu_params::PRF_IDX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               prv_valid,
    output logic               prv_ready,
    input  logic [ROB_IDX-1:0] in_rob_id,
    input  logic [PRF_IDX-1:0] in_rd_phy,
    input  logic [4:0]         in_rd_arch,
    input  logic [1:0]         in_fu_opcode,
    input  logic [XLEN-1:0]    in_rs1_value,
    input  logic [XLEN-1:0]    in_rs2_value,
    output logic               nxt_valid,
    input  logic               nxt_ready,
    output logic               cdb_valid,
    output logic [ROB_IDX-1:0] cdb_rob_id,
    output logic [PRF_IDX-1:0] cdb_rd_phy,
    output logic [4:0]         cdb_rd_arch,
    output logic [XLEN-1:0]    cdb_rd_value
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    md_div_op_t      op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic            q_neg;
    logic            r_neg;

    md_div_op_t      in_op;
    logic            in_signed;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic [XLEN-1:0] spec_val;
    logic            accept;

    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] result;

    assign prv_ready = (state == IDLE) && !flush;
    assign accept    = prv_valid && prv_ready;
    assign nxt_valid = cdb_valid;

    // Decode the incoming uop: operand magnitudes and the results that bypass iteration.
    always_comb begin
        in_op     = md_div_op_t'(in_fu_opcode);
        in_signed = (in_op == DIV) || (in_op == REM);
        rs1_abs   = (in_signed && in_rs1_value[XLEN-1]) ? -in_rs1_value : in_rs1_value;
        rs2_abs   = (in_signed && in_rs2_value[XLEN-1]) ? -in_rs2_value : in_rs2_value;
        div0      = (in_rs2_value == '0);
        ovf       = in_signed && (in_rs1_value == INT_MIN) && (in_rs2_value == '1);
        spec_val  = '0;
        if (div0) begin
            spec_val = ((in_op == DIV) || (in_op == DIVU)) ? '1 : in_rs1_value;
        end else if (in_op == DIV) begin
            spec_val = INT_MIN;
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .dvd_msb (dvd[XLEN-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Final-iteration result: sign fixup on the completed quotient/remainder.
    always_comb begin
        q_fin  = {dvd[XLEN-2:0], step_q};
        result = '0;
        if ((op_q == DIV) || (op_q == DIVU)) begin
            result = q_neg ? -q_fin : q_fin;
        end else begin
            result = r_neg ? -step_rem : step_rem;
        end
    end

    // Control FSM with datapath registers; flush overrides every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= DIV;
            cnt          <= '0;
            dvd          <= '0;
            rem          <= '0;
            divisor      <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            cdb_valid    <= 1'b0;
            cdb_rob_id   <= '0;
            cdb_rd_phy   <= '0;
            cdb_rd_arch  <= '0;
            cdb_rd_value <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            cdb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= in_op;
                        cdb_rob_id  <= in_rob_id;
                        cdb_rd_phy  <= in_rd_phy;
                        cdb_rd_arch <= in_rd_arch;
                        dvd         <= rs1_abs;
                        divisor     <= rs2_abs;
                        rem         <= '0;
                        q_neg       <= (in_op == DIV) && (in_rs1_value[XLEN-1] ^ in_rs2_value[XLEN-1]);
                        r_neg       <= (in_op == REM) && in_rs1_value[XLEN-1];
                        if (div0 || ovf) begin
                            cdb_rd_value <= spec_val;
                            cdb_valid    <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt   <= CW'(XLEN - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[XLEN-2:0], step_q};
                    if (cnt == '0) begin
                        cdb_rd_value <= result;
                        cdb_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (nxt_ready) begin
                        cdb_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
